// File: rtl/jsilicon_pkg.sv
// Shared types and constants for the UART result arbiter.
package jsilicon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SEND,
    GAP,
    WAIT
  } arb_state_t;

  localparam logic [7:0] TAG_BASE   = 8'hA0;
  localparam logic       REQ_MANUAL = 1'b0;
  localparam logic       REQ_CPU    = 1'b1;

endpackage

// File: rtl/uart_arbiter_req_buffer.sv
// One-entry valid/ready holding register; clear_i frees the slot once the arbiter has taken the word.
module req_buffer #(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ena,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              ready_o,
  input  logic              clear_i,
  output logic              full_o,
  output logic [WORD_W-1:0] data_o
);

  logic              full_q;
  logic [WORD_W-1:0] data_q;

  assign ready_o = ena & ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (ena) begin
      if (valid_i && ready_o) begin
        full_q <= 1'b1;
        data_q <= data_i;
      end else if (clear_i) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing one UART TX between two word producers, bytes sent LSB first.
// Optional UART_ARB_TAG_EN prefixes each word with a source tag byte (TAG_BASE | owner).
module uart_arbiter
  import jsilicon_pkg::*;
#(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ena,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              active,
  output logic              owner
);

  localparam int unsigned NBYTES  = WORD_W / 8;
`ifdef UART_ARB_TAG_EN
  localparam int unsigned NB_TOT  = NBYTES + 1;
  localparam int unsigned SHIFT_W = WORD_W + 8;
`else
  localparam int unsigned NB_TOT  = NBYTES;
  localparam int unsigned SHIFT_W = WORD_W;
`endif
  localparam int unsigned CNT_W   = $clog2(NB_TOT + 1);

  arb_state_t         state_q, state_d;
  logic               rr_q, rr_d;
  logic               owner_q, owner_d;
  logic               active_q, active_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  logic              buf0_full, buf1_full;
  logic [WORD_W-1:0] buf0_data, buf1_data;
  logic              clr0, clr1;
  logic              win;
  logic [WORD_W-1:0] win_word;

  req_buffer #(.WORD_W(WORD_W)) u_buf0 (
    .clock(clock), .reset(reset), .ena(ena),
    .valid_i(req0_valid), .data_i(req0_data), .ready_o(req0_ready),
    .clear_i(clr0), .full_o(buf0_full), .data_o(buf0_data)
  );

  req_buffer #(.WORD_W(WORD_W)) u_buf1 (
    .clock(clock), .reset(reset), .ena(ena),
    .valid_i(req1_valid), .data_i(req1_data), .ready_o(req1_ready),
    .clear_i(clr1), .full_o(buf1_full), .data_o(buf1_data)
  );

  // On contention the source not served last time wins.
  assign win      = (buf0_full && buf1_full) ? ~rr_q : buf1_full;
  assign win_word = (win == REQ_CPU) ? buf1_data : buf0_data;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    active_d   = active_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    clr0       = 1'b0;
    clr1       = 1'b0;
    case (state_q)
      IDLE: begin
        // Incoming captures count too, so a new word reaches ARB on the following cycle.
        if (buf0_full || buf1_full || (req0_valid && req0_ready) || (req1_valid && req1_ready))
          state_d = ARB;
      end
      ARB: begin
`ifdef UART_ARB_TAG_EN
        shift_d = {win_word, TAG_BASE | 8'(win)};
`else
        shift_d = win_word;
`endif
        clr0     = (win == REQ_MANUAL);
        clr1     = (win == REQ_CPU);
        owner_d  = win;
        rr_d     = win;
        active_d = 1'b1;
        cnt_d    = '0;
        state_d  = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = shift_q[7:0];
          state_d    = GAP;
        end
      end
      GAP: state_d = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (cnt_q < CNT_W'(NB_TOT - 1)) begin
            shift_d = shift_q >> 8;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SEND;
          end else begin
            active_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      active_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      cnt_q      <= '0;
      shift_q    <= '0;
    end else if (ena) begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      active_q   <= active_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
    end else begin
      tx_start_q <= 1'b0;
    end
  end

  assign tx_start = tx_start_q & ena;
  assign tx_data  = tx_data_q;
  assign active   = active_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter with a simple UART busy model and byte scoreboard.
module tb_uart_arbiter;

  localparam int BUSY_LEN = 4;
`ifdef UART_ARB_TAG_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ena = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        tx_start, tx_busy, active, owner;
  logic [7:0]  tx_data;

  int          errors = 0;
  int          checks = 0;
  int          busy_cnt = 0;
  logic        busy_force = 1'b0;
  int          viol = 0;
  logic [7:0]  sent[$];
  logic [7:0]  exp_q[$];

  uart_arbiter #(.WORD_W(16)) dut (
    .clock(clock), .reset(reset), .ena(ena),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .active(active), .owner(owner)
  );

  always #5 clock = ~clock;

  // UART model: busy rises the cycle after a start pulse and lasts BUSY_LEN cycles.
  assign tx_busy = (busy_cnt != 0) | busy_force;
  always @(posedge clock) begin
    if (tx_start) begin
      if (tx_busy) viol++;
      sent.push_back(tx_data);
      busy_cnt <= BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add_word(input logic src, input logic [15:0] w);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back(8'hA0 | {7'b0, src});
`endif
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (!((sent.size() >= n) && !active) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(sent.size()), 32'(n));
  endtask

  task automatic check_stream(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < sent.size()) check(tag, {24'b0, sent[i]}, {24'b0, exp_q[i]});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sent.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    tick();
    check("rst_tx_start", {31'b0, tx_start}, 0);
    check("rst_tx_data", {24'b0, tx_data}, 0);
    check("rst_active", {31'b0, active}, 0);
    check("rst_owner", {31'b0, owner}, 0);
    check("rst_ready0", {31'b0, req0_ready}, 1);
    check("rst_ready1", {31'b0, req1_ready}, 1);
    do_reset();

    // single word and latency
    req0_valid = 1'b1; req0_data = 16'h1234;
    tick();
    req0_valid = 1'b0;
    check("single_ready_full", {31'b0, req0_ready}, 0);
    tick();
    check("single_active", {31'b0, active}, 1);
    check("single_ready_freed", {31'b0, req0_ready}, 1);
    tick();
    check("single_latency_start", {31'b0, tx_start}, 1);
    check("single_first_byte", {24'b0, tx_data}, 8'h34);
    add_word(1'b0, 16'h1234);
    wait_bytes("single_count", NB, 200);
    check_stream("single_stream");
    check("single_owner", {31'b0, owner}, 0);
    check("single_inactive", {31'b0, active}, 0);

    // contention straight after reset: requester 1 first
    do_reset();
    req0_valid = 1'b1; req0_data = 16'hAAAA;
    req1_valid = 1'b1; req1_data = 16'h5555;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("cont_first_owner", {31'b0, owner}, 1);
    add_word(1'b1, 16'h5555);
    add_word(1'b0, 16'hAAAA);
    wait_bytes("cont_count", 2 * NB, 400);
    check_stream("cont_stream");
    check("cont_last_owner", {31'b0, owner}, 0);

    // busy stall
    sent.delete(); exp_q.delete();
    busy_force = 1'b1;
    req1_valid = 1'b1; req1_data = 16'hC3D4;
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("stall_no_pulse", 32'(sent.size()), 0);
    busy_force = 1'b0;
    tick(); tick(); tick();
    check("stall_one_pulse", 32'(sent.size()), 1);
    add_word(1'b1, 16'hC3D4);
    wait_bytes("stall_count", NB, 200);
    check_stream("stall_stream");

    // backpressure on requester 0
    sent.delete(); exp_q.delete();
    req0_valid = 1'b1; req0_data = 16'h1111;
    tick();
    req0_valid = 1'b0;
    tick();
    check("bp_second_ready", {31'b0, req0_ready}, 1);
    req0_valid = 1'b1; req0_data = 16'h2222;
    tick();
    req0_data = 16'h3333;
    check("bp_third_blocked", {31'b0, req0_ready}, 0);
    n = 0;
    while (!req0_ready && n < 200) begin
      tick();
      n++;
    end
    check("bp_sent_at_ready", 32'(sent.size()), 32'(NB));
    tick();
    req0_valid = 1'b0;
    add_word(1'b0, 16'h1111);
    add_word(1'b0, 16'h2222);
    add_word(1'b0, 16'h3333);
    wait_bytes("bp_count", 3 * NB, 600);
    check_stream("bp_stream");

    // reset mid-word drops the rest
    sent.delete(); exp_q.delete();
    req0_valid = 1'b1; req0_data = 16'hBEEF;
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (sent.size() < 1 && n < 100) begin
      tick();
      n++;
    end
    reset = 1'b1;
    #1;
    check("midrst_tx_start", {31'b0, tx_start}, 0);
    check("midrst_active", {31'b0, active}, 0);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_ready0", {31'b0, req0_ready}, 1);
    check("midrst_ready1", {31'b0, req1_ready}, 1);
    for (int i = 0; i < 30; i++) tick();
    check("midrst_count", 32'(sent.size()), 1);
`ifdef UART_ARB_TAG_EN
    if (sent.size() > 0) check("midrst_byte", {24'b0, sent[0]}, 8'hA0);
`else
    if (sent.size() > 0) check("midrst_byte", {24'b0, sent[0]}, 8'hEF);
`endif

    // ena low during WAIT freezes progress
    sent.delete(); exp_q.delete();
    req1_valid = 1'b1; req1_data = 16'h9A8B;
    tick();
    req1_valid = 1'b0;
    n = 0;
    while (sent.size() < 1 && n < 100) begin
      tick();
      n++;
    end
    ena = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start) n++;
    end
    check("ena_no_start", 32'(n), 0);
    check("ena_no_bytes", 32'(sent.size()), 1);
    check("ena_active_held", {31'b0, active}, 1);
    check("ena_ready_low", {31'b0, req0_ready}, 0);
    ena = 1'b1;
    add_word(1'b1, 16'h9A8B);
    wait_bytes("ena_count", NB, 200);
    check_stream("ena_stream");

    check("no_pulse_while_busy", 32'(viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_arbiter.md
Name: uart_arbiter

Overview:
- Shares the single UART transmitter between two result producers: requester 0 (manual-mode ALU results) and requester 1 (CPU-mode write-back trace).
- Each requester has a one-entry holding buffer behind a valid/ready handshake.
- A round-robin FSM picks a buffered word, splits it into bytes (LSB first) and issues them to the UART one at a time using a start/busy handshake.
- Sits between the FSM/ALU result path and the UART TX inside the top level.

Parameters:
- WORD_W, 16, requester word width in bits; multiple of 8, legal range 8..32; NBYTES = WORD_W/8.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ena  in  1  global enable; when low, all state is frozen
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WORD_W  requester 0 word
- req0_ready  out  1  requester 0 buffer can accept
- req1_valid  in  1  requester 1 has a word
- req1_data  in  WORD_W  requester 1 word
- req1_ready  out  1  requester 1 buffer can accept
- tx_start  out  1  one-cycle pulse: UART loads tx_data
- tx_data  out  8  byte to transmit
- tx_busy  in  1  UART is shifting
- active  out  1  a word is being sent
- owner  out  1  source of the word being sent (0/1)

Behaviour:
- Interface decision: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: all state clears to IDLE, both buffers empty, rr pointer = 0, tx_start = 0, tx_data = 0, active = 0, owner = 0.
- reqN_ready = ena & ~bufN_full (combinational). A word is captured on a clock edge where reqN_valid & reqN_ready; bufN_full is set on that edge.
- ena = 0:
  - No state, buffer or pointer updates.
  - tx_start is forced to 0.
  - Other outputs hold.
- FSM states: IDLE, ARB, SEND, GAP, WAIT.
- IDLE:
  - Goes to ARB when at least one buffer is full; otherwise stays.
- ARB (one cycle):
  - Winner selection:
    - Only one buffer full: that buffer wins.
    - Both full: the winner is ~rr.
  - Load the shift register with the winner's word, clear the winner's buffer, set owner = winner, rr = winner, active = 1, byte counter = 0, then go to SEND.
  - The freed buffer shows ready the next cycle, not in ARB.
- SEND:
  - If tx_busy = 0: register tx_start = 1 and tx_data = shift[7:0], then go to GAP.
  - Otherwise stay in SEND; never pulse while busy.
- GAP (one cycle):
  - tx_start returns to 0.
  - tx_busy is ignored here because the UART raises busy one cycle after start.
  - Go to WAIT.
- WAIT: stay until tx_busy = 0, then:
  - Counter < NBYTES-1: shift right by 8, increment the counter, go to SEND.
  - Otherwise: active = 0, go to IDLE.
- Latency: word captured at edge N → ARB at N+1 → tx_start high in the cycle after edge N+2 (if the UART is idle).
- Back-to-back words: IDLE costs one cycle between words, so a full buffer is never starved. Round-robin gives strict alternation under continuous load from both requesters.
- A buffer may fill while its own previous word is being sent; order per requester is preserved.
- Reset mid-word: the partial word is dropped, tx_start is forced low immediately (asynchronously), and no trailing bytes are sent.
- tx_data holds its last value outside of pulses.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined: each word is preceded by a tag byte 8'hA0 | owner, sent through the same SEND/GAP/WAIT sequence, so NBYTES+1 bytes go out per word. This lets the host demultiplex the two sources.
- Undefined: only NBYTES data bytes are sent; no tag logic is present.

Decomposition:
- Package jsilicon_pkg holds:
  - the arb_state_t enum (IDLE, ARB, SEND, GAP, WAIT)
  - the TAG_BASE = 8'hA0 constant
  - the REQ_MANUAL = 0 and REQ_CPU = 1 source IDs
- Sub-module req_buffer (one-entry valid/ready holding register with a clear input) is instantiated twice.

Test Plan:
- Single word: req0 sends 16'h1234 with UART idle → tx_start pulses with tx_data = 8'h34, then 8'h12; active falls after the second WAIT; owner = 0.
- Contention: req0 = 16'hAAAA and req1 = 16'h5555 in the same cycle after reset → req1 served first (rr = 0), then req0; with UART_ARB_TAG_EN the byte stream is A1 55 55 A0 AA AA.
- Busy stall: hold tx_busy = 1 for 20 cycles while in SEND → no tx_start until busy falls, then exactly one pulse.
- Backpressure: while req0's word is sending, present a second req0 word → accepted (ready = 1); a third word sees ready = 0 until the buffer moves to ARB.
- Reset mid-word: assert reset after the first byte of 16'hBEEF → no 8'hBE is sent; buffers empty, ready = 1 once reset is released and ena = 1.
- ena low: deassert ena during WAIT for 10 cycles while tx_busy falls → no progress and tx_start = 0; resumes with the next byte after ena returns.
